// File: rtl/wave_voice.sv
// Single-voice oscillator: phase accumulator shaped into saw/triangle/pulse/noise (WAVE_VOICE_NOISE_EN builds the LFSR).
// Latency: accepted tick in cycle N -> sample/sample_valid/wrap in cycle N+1.
// Backpressure: none; every accepted tick produces exactly one sample_valid pulse.
module wave_voice #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             sample_tick,
    input  logic [ACC_W-1:0] step,
    input  logic [1:0]       mode,
    input  logic [OUT_W-1:0] pulse_width,
    input  logic             phase_rst,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    output logic             wrap
);

    logic             acc_en;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [OUT_W-1:0] q_next;
    logic [OUT_W-1:0] tri_val;
    logic [OUT_W-1:0] pulse_val;
    logic [OUT_W-1:0] noise_val;
    logic [OUT_W-1:0] shaped;

    assign acc_en = en & sample_tick & ~phase_rst;
    assign sum    = {1'b0, acc} + {1'b0, step};
    assign q_next = sum[ACC_W-1 -: OUT_W];

    // Rising half doubles q; falling half is the inverted mirror.
    assign tri_val   = {q_next[OUT_W-2:0], 1'b0} ^ {OUT_W{q_next[OUT_W-1]}};
    assign pulse_val = (q_next >= pulse_width) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

`ifdef WAVE_VOICE_NOISE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    // Advances only on phase overflow so noise colour follows pitch.
    always_comb begin
        lfsr_next = lfsr;
        if (sum[ACC_W])
            lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign noise_val = lfsr_next[15 -: OUT_W];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            lfsr <= 16'hACE1;
        else if (acc_en)
            lfsr <= lfsr_next;
    end
`else
    assign noise_val = {OUT_W{1'b0}};
`endif

    always_comb begin
        shaped = q_next;
        case (mode)
            2'b00:   shaped = q_next;
            2'b01:   shaped = tri_val;
            2'b10:   shaped = pulse_val;
            default: shaped = noise_val;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            sample_valid <= acc_en;
            wrap         <= acc_en & sum[ACC_W];
            if (phase_rst)
                acc <= '0;
            else if (acc_en) begin
                acc    <= sum[ACC_W-1:0];
                sample <= shaped;
            end
        end
    end

endmodule

// File: doc/wave_voice.md
# wave_voice

Parametrised single-voice oscillator for the synth datapath. A phase accumulator advances by a programmable step on each sample tick. Its top bits are shaped into saw, triangle, variable-width pulse or LFSR noise, and the result is registered with a one-cycle valid strobe. The block sits between the note/pitch control logic and the mixer/PWM output stage.

## Interface
Parameters:
- `ACC_W`, default 16: phase accumulator width; must be ≥ `OUT_W`.
- `OUT_W`, default 8: sample width. Shaping uses `q = acc[ACC_W-1 -: OUT_W]`. Must be ≤ 16 when noise is compiled in.

Ports:
- `clk`, input, 1: system clock; everything is rising-edge.
- `n_rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: voice enable; when low, ticks are ignored.
- `sample_tick`, input, 1: single-cycle sample-rate strobe.
- `step`, input, `ACC_W`: phase increment per tick.
- `mode`, input, 2: 00 saw, 01 triangle, 10 pulse, 11 noise.
- `pulse_width`, input, `OUT_W`: pulse threshold.
- `phase_rst`, input, 1: synchronous phase clear (note retrigger).
- `sample`, output, `OUT_W`: registered waveform sample.
- `sample_valid`, output, 1: one-cycle pulse when `sample` updates.
- `wrap`, output, 1: one-cycle pulse when the accumulator overflows.

## Operation
- Accept condition: `acc_en = en & sample_tick & ~phase_rst`.
- On accept:
  - `{carry, acc_next} = acc + step`; the sum is modulo 2^ACC_W.
  - `acc <= acc_next` and `wrap <= carry`.
  - `sample <= shape(q_next)`, where `q_next` is the top `OUT_W` bits of `acc_next`.
  - `sample_valid <= 1`.
- Shapes (M = 2^OUT_W − 1):
  - saw: `q_next`.
  - triangle: if MSB of `q_next` is 0, `{q_next[OUT_W-2:0],1'b0}`; otherwise the bitwise inverse of that value. For OUT_W = 8 this gives 0→0, 127→254, 128→255, 255→1.
  - pulse: `q_next >= pulse_width ? M : 0`. `pulse_width` = 0 gives constant M. `pulse_width` = 2^(OUT_W−1) gives a 50% square.
  - noise: see Configuration.
- `phase_rst` high:
  - `acc <= 0`.
  - `sample` holds; `sample_valid` and `wrap` are 0.
  - A tick in the same cycle is dropped, so `phase_rst` has priority.
- `en` low: `acc`, `sample` and LFSR hold; `sample_valid` and `wrap` are 0.
- `step` = 0: each tick re-emits the same sample with `sample_valid` = 1; `wrap` never fires.
- `mode`, `step` and `pulse_width` are sampled only on accept cycles. A change takes effect at the next accepted tick and does not glitch `sample`.

## Timing
- Latency: tick in cycle N → `sample`, `sample_valid` and `wrap` valid in cycle N+1.
- `sample_valid` and `wrap` stay high for exactly one cycle per accepted tick. Back-to-back ticks produce back-to-back pulses.
- Reset values:
  - `acc` = 0, `sample` = 0, `sample_valid` = 0, `wrap` = 0.
  - LFSR = 16'hACE1.
- Asserting `n_rst` mid-operation clears all state immediately; no pulse is emitted on release.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
`WAVE_VOICE_NOISE_EN`:
- Defined: the block contains a 16-bit Galois LFSR.
  - Shift right; if the old bit 0 is 1, XOR with 16'hB400.
  - It advances only on accepted ticks where `carry` = 1, so noise colour tracks pitch.
  - In mode 11, `sample <=` the top `OUT_W` bits of the LFSR value after any advance in that cycle.
  - `phase_rst` does not reseed the LFSR.
- Undefined: no LFSR is built. Mode 11 yields `sample` = 0, with `sample_valid` and `wrap` still behaving normally.

## Test plan
- **Saw:** ACC_W=16, OUT_W=8, step=16'h0100, mode 00, 3 ticks → `sample` = 1, 2, 3, each with one `sample_valid` pulse one cycle after its tick.
- **Triangle:** step=16'h7F00, mode 01, 1 tick → 254. Then step=16'h0100, 1 tick → 255 (q = 128). Then step=16'h7F00, 1 tick (q = 255) → 1.
- **Pulse:** pulse_width=64, step=16'h3F00, mode 10 → 0 (q = 63). Next tick with step=16'h0100 → 255 (q = 64). pulse_width=0 → every sample 255.
- **Wrap and priority:**
  - step=16'h8000, 2 ticks → `wrap` = 0 then 1, `acc` = 0.
  - `phase_rst` with a simultaneous tick → no `sample_valid`, `acc` = 0, `sample` unchanged.
  - `en` = 0 with a tick → no change.
- **Noise (macro defined):**
  - step=16'h8000, mode 11.
  - First tick (no wrap) → `sample` = 8'hAC.
  - Second tick (wrap) → LFSR = 16'hE270, `sample` = 8'hE2.
  - Without the macro, both ticks → 0.
- **Reset:** drop `n_rst` asynchronously between clock edges mid-stream → all outputs 0 immediately. After release, the first tick with step=16'h0100 in saw mode → 1.
